dds_rom_sched: RTL and testbench
================================

# dds_rom_sched

Two-channel DDS sequencer that time-shares a single synchronous waveform ROM (4096 x 14, address registered inside the ROM, unregistered output) between two phase accumulators. Each channel has its own tuning word, phase offset and enable, all loaded through a valid/ready configuration port. The block sits between the frequency/waveform control logic and the DAC output stage of the waveform generator. It drives the ROM address, then returns one 14-bit sample per enabled channel every 2 clocks.

## Interface
- ACC_W, 32, phase accumulator width
- ADDR_W, 12, ROM address width; equals the top ADDR_W bits of the accumulator
- DATA_W, 14, ROM/sample width
- clock  in  1  single clock; also clocks the ROM
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready at a rising edge
- cfg_ch  in  1  target channel (0/1)
- cfg_ftw  in  ACC_W  frequency tuning word
- cfg_pofs  in  ADDR_W  phase offset added to the address
- cfg_en  in  1  channel enable
- sync_i  in  1  phase reset for both channels
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM data, valid one cycle after the ROM samples rom_addr
- ch0_data, ch1_data  out  DATA_W  last sample per channel
- ch0_valid, ch1_valid  out  1  one-cycle strobe when the matching chN_data updates

## Operation
- Reset values: acc0/acc1 = 0, ftw = 0, pofs = 0, en = 0, slot = 0, rom_addr = 0, chN_data = 0, chN_valid = 0, cfg_ready = 1. Both pipeline tag stages are cleared.
- Slot scheduler: `slot` toggles every clock. Slot s belongs to channel s.
- Issue (edge with slot == s, en_s = 1, sync_i = 0):
  - rom_addr <= acc_s[ACC_W-1 -: ADDR_W] + pofs_s, modulo 2^ADDR_W.
  - acc_s <= acc_s + ftw_s, modulo 2^ACC_W.
  - tag stage 1 <= {1, s}.
- If en_s = 0 in its slot: no issue, acc_s holds, rom_addr holds, tag stage 1 <= invalid.
- Return path:
  - tag stage 2 <= tag stage 1.
  - At the edge where tag stage 2 is valid with channel c: ch_c_data <= rom_q, and ch_c_valid is high for exactly the following cycle.
  - ch_c_data holds between updates.
- Config handshake:
  - On accept, {ch, ftw, pofs, en} are staged and cfg_ready goes low.
  - The staged values commit at the first later edge where slot != staged ch. The channel's next slot then uses the new values.
  - cfg_ready returns high in the cycle after the commit edge.
  - cfg_valid is ignored while cfg_ready is low.
  - Commit does not touch acc, so enabling or retuning a channel is phase-continuous.
- sync_i high at an edge:
  - acc0 and acc1 <= 0; slot <= 0.
  - No issue at that edge; in-flight tags still complete and strobe.
  - A commit that falls on the same edge still occurs.

## Timing
- Sample latency: issue at edge n → ROM samples at n+1 → capture at n+2; chN_valid is high during cycle n+2.
- Per-channel sample rate: one sample per 2 clocks when enabled. The two channels' strobes alternate and are never high together.
- Config latency: accept at edge A, commit at A+1 or A+2, cfg_ready high one cycle after commit. cfg_ready is therefore low for 2 or 3 cycles.
- Reset assertion mid-operation: all outputs return to reset values immediately and asynchronously. Any staged config and in-flight tags are discarded.

## Test plan
- Reset mid-run:
  - Stimulus: ch0 running with strobes; pulse rst_n low for 3 cycles.
  - Required response: outputs are immediately 0 and cfg_ready = 1. After release, no chN_valid appears until a channel is configured again.
- Single channel, step 1:
  - Setup: ROM model q = {2'b00, addr}; configure ch0 with ftw = 0x00100000, pofs = 0, en = 1.
  - Required response: rom_addr sequence 0, 1, 2, … on alternate edges.
  - ch0_valid pulses every 2 cycles with ch0_data 0, 1, 2, …, each 2 cycles after its issue. ch1_valid stays 0.
- Dual channel:
  - Stimulus: add ch1 with ftw = 0x00400000, pofs = 0x800.
  - Required response: ch1_data follows 0x800, 0x804, 0x808, …, interleaved with ch0.
  - ch0_valid and ch1_valid never overlap.
- Wrap-around:
  - Stimulus: ch0 ftw = 0xFFF00000, pofs = 0.
  - Required response: addresses follow 0x000, 0xFFF, 0xFFE, …
  - With pofs = 0xFFF and ftw = 0x00100000, addresses follow 0xFFF, 0x000, 0x001.
- Live retune:
  - Stimulus: while ch0 runs at step 1, assert cfg_valid for ch0 with ftw = 0x00200000, and hold cfg_valid high through the ready-low window.
  - Required response: cfg_ready is low for 2–3 cycles. The first ch0 issue after commit advances by 1, and later issues advance by 2 from the unchanged phase.
  - Exactly one config is accepted.
- Sync:
  - Stimulus: pulse sync_i for 1 cycle while both channels run.
  - Required response: in-flight samples still strobe. The next ch0 issue uses address pofs0, and the following ch1 issue uses address pofs1.

Source files
------------

// File: rtl/dds_rom_sched.sv
// Two-channel DDS sequencer sharing one synchronous waveform ROM.
// Even slots issue channel 0 and odd slots issue channel 1. Each ROM read
// is tagged, and the tag travels two stages so that the returning sample
// lands in the right channel's output register.
// Configuration is staged on accept. It commits only in the other
// channel's slot, so a channel's parameters never change under an issue
// that is already under way.
//
// Config FSM states:
//   state    | meaning
//   CFG_IDLE | cfg_ready high, waiting for a request
//   CFG_PEND | request staged, waiting for a slot of the other channel
//   CFG_DONE | committed this edge, cfg_ready stays low one more cycle
module dds_rom_sched #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 14
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_ch,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ADDR_W-1:0] cfg_pofs,
    input  logic              cfg_en,
    input  logic              sync_i,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] ch0_data,
    output logic [DATA_W-1:0] ch1_data,
    output logic              ch0_valid,
    output logic              ch1_valid
);

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_PEND = 2'd1,
        CFG_DONE = 2'd2
    } cfg_state_t;

    cfg_state_t        cfg_st;
    cfg_state_t        cfg_nxt;

    logic [ACC_W-1:0]  acc   [2];
    logic [ACC_W-1:0]  ftw   [2];
    logic [ADDR_W-1:0] pofs  [2];
    logic              en    [2];
    logic              slot;

    logic              stg_ch;
    logic [ACC_W-1:0]  stg_ftw;
    logic [ADDR_W-1:0] stg_pofs;
    logic              stg_en;

    logic              tag1_v;
    logic              tag1_ch;
    logic              tag2_v;
    logic              tag2_ch;

    logic              accept;
    logic              commit;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;

    assign cfg_ready  = (cfg_st == CFG_IDLE);
    assign accept     = cfg_valid && cfg_ready;
    assign issue      = !sync_i && en[slot];
    assign issue_addr = acc[slot][ACC_W-1 -: ADDR_W] + pofs[slot];

    // Config FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cfg_st <= CFG_IDLE;
        end else begin
            cfg_st <= cfg_nxt;
        end
    end

    // Config FSM next state and commit decision
    always_comb begin
        cfg_nxt = cfg_st;
        commit  = 1'b0;
        case (cfg_st)
            CFG_IDLE: if (accept) cfg_nxt = CFG_PEND;
            CFG_PEND: begin
                if (slot != stg_ch) begin
                    commit  = 1'b1;
                    cfg_nxt = CFG_DONE;
                end
            end
            CFG_DONE: cfg_nxt = CFG_IDLE;
            default:  cfg_nxt = CFG_IDLE;
        endcase
    end

    // Staging of accepted config and commit into the channel registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stg_ch   <= 1'b0;
            stg_ftw  <= '0;
            stg_pofs <= '0;
            stg_en   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ftw[i]  <= '0;
                pofs[i] <= '0;
                en[i]   <= 1'b0;
            end
        end else begin
            if (accept) begin
                stg_ch   <= cfg_ch;
                stg_ftw  <= cfg_ftw;
                stg_pofs <= cfg_pofs;
                stg_en   <= cfg_en;
            end
            if (commit) begin
                ftw[stg_ch]  <= stg_ftw;
                pofs[stg_ch] <= stg_pofs;
                en[stg_ch]   <= stg_en;
            end
        end
    end

    // Slot scheduler, phase accumulators and ROM address issue
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= 1'b0;
            acc[0]   <= '0;
            acc[1]   <= '0;
            rom_addr <= '0;
            tag1_v   <= 1'b0;
            tag1_ch  <= 1'b0;
        end else begin
            tag1_v  <= issue;
            tag1_ch <= slot;
            if (sync_i) begin
                slot   <= 1'b0;
                acc[0] <= '0;
                acc[1] <= '0;
            end else begin
                slot <= ~slot;
                if (issue) begin
                    acc[slot] <= acc[slot] + ftw[slot];
                    rom_addr  <= issue_addr;
                end
            end
        end
    end

    // Return path: tag follows the ROM read, sample captured into its channel
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tag2_v    <= 1'b0;
            tag2_ch   <= 1'b0;
            ch0_data  <= '0;
            ch1_data  <= '0;
            ch0_valid <= 1'b0;
            ch1_valid <= 1'b0;
        end else begin
            tag2_v    <= tag1_v;
            tag2_ch   <= tag1_ch;
            ch0_valid <= tag2_v && !tag2_ch;
            ch1_valid <= tag2_v && tag2_ch;
            if (tag2_v && !tag2_ch) ch0_data <= rom_q;
            if (tag2_v && tag2_ch)  ch1_data <= rom_q;
        end
    end

endmodule

// File: tb/tb_dds_rom_sched.sv
// Bench for dds_rom_sched: directed scenarios followed by random traffic.
// Every cycle is checked against a reference model of the sequencer.
module tb_dds_rom_sched;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_ch = 1'b0;
    logic [31:0] cfg_ftw = '0;
    logic [11:0] cfg_pofs = '0;
    logic        cfg_en = 1'b0;
    logic        sync_i = 1'b0;
    logic [11:0] rom_addr;
    logic [13:0] rom_q;
    logic [13:0] ch0_data, ch1_data;
    logic        ch0_valid, ch1_valid;
    logic [11:0] rom_reg;

    int n_tests = 0;
    int n_fail  = 0;

    dds_rom_sched dut (
        .clock(clock), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_ftw(cfg_ftw), .cfg_pofs(cfg_pofs), .cfg_en(cfg_en),
        .sync_i(sync_i), .rom_addr(rom_addr), .rom_q(rom_q),
        .ch0_data(ch0_data), .ch1_data(ch1_data),
        .ch0_valid(ch0_valid), .ch1_valid(ch1_valid)
    );

    always #5 clock = ~clock;

    // ROM model: registered address, sample equals the address
    always @(posedge clock) rom_reg <= rom_addr;
    assign rom_q = {2'b00, rom_reg};

    // Reference model
    typedef struct {
        int         due;
        bit         ch;
        logic [11:0] addr;
    } exp_t;

    exp_t        cap_q[$];
    int          m_n, m_cnt;
    logic [31:0] m_acc[2], m_ftw[2];
    logic [11:0] m_pofs[2];
    bit          m_en[2];
    logic [11:0] m_rom_addr;
    bit          m_pend, m_done, m_accepted;
    bit          m_stg_ch, m_stg_en;
    logic [31:0] m_stg_ftw;
    logic [11:0] m_stg_pofs;
    logic [13:0] m_data[2];
    bit          m_valid[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        cap_q.delete();
        m_n = 0; m_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_ftw[i] = 0; m_pofs[i] = 0; m_en[i] = 0;
            m_data[i] = 0; m_valid[i] = 0;
        end
        m_rom_addr = 0;
        m_pend = 0; m_done = 0; m_accepted = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        int s;
        bit ready;
        logic [11:0] a;
        exp_t e;
        m_accepted = 0;
        s = m_cnt % 2;
        m_valid[0] = 0;
        m_valid[1] = 0;
        while (cap_q.size() > 0 && cap_q[0].due == m_n) begin
            e = cap_q.pop_front();
            m_valid[e.ch] = 1;
            m_data[e.ch]  = {2'b00, e.addr};
        end
        if (sync_i) begin
            m_acc[0] = 0;
            m_acc[1] = 0;
            m_cnt = 0;
        end else begin
            if (m_en[s]) begin
                a = 12'(m_acc[s] >> 20) + m_pofs[s];
                m_rom_addr = a;
                m_acc[s] = m_acc[s] + m_ftw[s];
                e.due = m_n + 2;
                e.ch = (s == 1);
                e.addr = a;
                cap_q.push_back(e);
            end
            m_cnt++;
        end
        ready = !m_pend && !m_done;
        m_done = 0;
        if (m_pend && s != int'(m_stg_ch)) begin
            m_ftw[m_stg_ch]  = m_stg_ftw;
            m_pofs[m_stg_ch] = m_stg_pofs;
            m_en[m_stg_ch]   = m_stg_en;
            m_pend = 0;
            m_done = 1;
        end
        if (cfg_valid && ready) begin
            m_pend = 1;
            m_stg_ch = cfg_ch;
            m_stg_ftw = cfg_ftw;
            m_stg_pofs = cfg_pofs;
            m_stg_en = cfg_en;
            m_accepted = 1;
        end
        m_n++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("rom_addr", rom_addr, m_rom_addr);
        check("cfg_ready", cfg_ready, !m_pend && !m_done);
        check("ch0_valid", ch0_valid, m_valid[0]);
        check("ch1_valid", ch1_valid, m_valid[1]);
        check("ch0_data", ch0_data, m_data[0]);
        check("ch1_data", ch1_data, m_data[1]);
        check("valid_overlap", ch0_valid & ch1_valid, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_rdy"}, cfg_ready, 1);
        check({tag, "_d0"}, ch0_data, 0);
        check({tag, "_d1"}, ch1_data, 0);
        check({tag, "_v"}, {ch0_valid, ch1_valid}, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst_hold");
        model_reset();
        cfg_valid = 0;
        sync_i = 0;
        rst_n = 1;
    endtask

    task automatic do_cfg(input bit ch, input logic [31:0] ftw, input logic [11:0] pofs, input bit en);
        int k, n, lows;
        bit acc;
        cfg_ch = ch; cfg_ftw = ftw; cfg_pofs = pofs; cfg_en = en;
        cfg_valid = 1;
        acc = 0;
        k = 0;
        while (!acc && k < 10) begin
            step();
            acc = m_accepted;
            k++;
        end
        check("cfg_accept_timeout", acc, 1);
        lows = (cfg_ready == 0) ? 1 : 0;
        n = 0;
        while (!cfg_ready && n < 6) begin
            cfg_valid = (n < 2);
            step();
            if (!cfg_ready) lows++;
            n++;
        end
        cfg_valid = 0;
        check("rdy_low_window", (lows >= 2 && lows <= 3), 1);
    endtask

    task automatic sync_pulse();
        sync_i = 1;
        step();
        sync_i = 0;
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_outputs("por");
        #12;
        rst_n = 1;
        run(6);

        // single channel, step 1
        do_cfg(0, 32'h0010_0000, 12'h000, 1);
        run(20);
        // add ch1
        do_cfg(1, 32'h0040_0000, 12'h800, 1);
        run(20);
        // live retune of ch0
        do_cfg(0, 32'h0020_0000, 12'h000, 1);
        run(10);
        // sync both channels
        sync_pulse();
        run(10);
        // wrap-around, descending
        do_cfg(1, 32'h0040_0000, 12'h800, 0);
        do_cfg(0, 32'hFFF0_0000, 12'h000, 1);
        sync_pulse();
        run(10);
        // wrap-around through offset
        do_cfg(0, 32'h0010_0000, 12'hFFF, 1);
        sync_pulse();
        run(8);
        // reset while running, then idle with nothing configured
        reset_pulse();
        run(10);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cfg_valid = ($urandom % 6 == 0);
            cfg_ch    = 1'($urandom);
            cfg_ftw   = ($urandom % 2) ? $urandom : (($urandom % 8) << 20);
            cfg_pofs  = 12'($urandom);
            cfg_en    = ($urandom % 4) != 0;
            sync_i    = ($urandom % 40 == 0);
            step();
            if (i % 600 == 599) reset_pulse();
        end
        cfg_valid = 0;
        sync_i = 0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
